piso_arbiter: RTL and testbench
===============================

PISO_ARBITER -- requirements
Module: piso_arbiter

Interface
REQ-001 SHALL have parameter W, default 4, giving the data word width in bits (W >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-004 SHALL have port req0_valid, input, 1 bit: requester 0 offers a word.
REQ-005 SHALL have port req0_data, input, W bits: requester 0 word.
REQ-006 SHALL have port req0_ready, output, 1 bit: requester 0 word accepted this cycle.
REQ-007 SHALL have ports req1_valid, req1_data and req1_ready, identical to the requester 0 ports but for requester 1.
REQ-008 SHALL have port sout, output, 1 bit: serial data, LSB first.
REQ-009 SHALL have port sout_valid, output, 1 bit: sout carries a frame bit this cycle.
REQ-010 SHALL have port grant_id, output, 1 bit: owner of the current or last frame.
REQ-011 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse on the last frame bit.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT only.
REQ-014 SHALL, in IDLE, grant combinationally: only one valid selects that requester; both valid selects the round-robin pointer rr.
REQ-015 SHALL assert reqN_ready only in IDLE and only for the granted requester; at most one ready is high per cycle.
REQ-016 SHALL, on a valid&ready edge, load the granted data into the shift register, set grant_id, clear the bit counter and enter SHIFT.
REQ-017 SHALL, in SHIFT, drive sout = shreg[0] with sout_valid=1 and busy=1, shifting right with zero fill each cycle.
REQ-018 SHALL emit exactly FL bits per frame, where FL = W, or W+1 when parity is enabled (REQ-025); the first bit appears the cycle after the handshake.
REQ-019 SHALL, on the last bit, pulse frame_done, set rr to the non-granted requester, and return to IDLE.
REQ-020 SHALL spend one IDLE cycle between frames, giving a throughput of one word per FL+1 cycles.
REQ-021 SHALL ignore reqN_data and reqN_valid changes during SHIFT; reqN_ready stays 0 in SHIFT.
REQ-022 SHALL make sout_valid, busy and frame_done registered outputs; sout SHALL be 0 whenever sout_valid=0.
REQ-023 SHALL size the bit counter to $clog2(W+1) bits, with no wrap inside a frame.

Reset
REQ-024 SHALL, on reset=0, force state=IDLE, shreg=0, counter=0, rr=0, grant_id=0, sout=0, sout_valid=0, busy=0 and frame_done=0; a frame in progress is aborted with no frame_done, and the ready outputs are 0 during reset.

Configuration
REQ-025 SHALL, with PISO_ARBITER_PARITY_EN defined, append one even-parity bit (XOR of the loaded word) after the W data bits, so FL=W+1; without the macro, FL=W and no parity logic is present.

Structure
REQ-026 SHALL place the FSM state typedef (IDLE/SHIFT) and the requester-index constants in shared package piso_pkg.
REQ-027 SHALL instantiate sub-module piso_shifter (load, shift enable, W-bit parallel in, serial out), holding the shift register.

Verification
REQ-028 SHALL cover: reset=0 then 1, req0_valid=1 with data 4'b1011 -> req0_ready=1 for 1 cycle; sout=1,1,0,1 with sout_valid=1 for 4 cycles; frame_done on bit 4; grant_id=0.
REQ-029 SHALL cover: both valid, data0=4'hA and data1=4'h5 held -> frames in order req0 (0,1,0,1) then req1 (1,0,1,0), one idle cycle between, 10 cycles total.
REQ-030 SHALL cover: only req1 valid, data 4'hF, with rr=0 -> req1 granted immediately, sout=1,1,1,1.
REQ-031 SHALL cover: reset=0 during the 2nd shift bit -> next cycle sout_valid=0, busy=0, no frame_done; after release, req0 with 4'h3 is served first.
REQ-032 SHALL cover: PISO_ARBITER_PARITY_EN defined, data 4'b0111 -> sout=1,1,1,0,1 (parity 1), 5 valid bits.
REQ-033 SHALL cover: data changed mid-frame (4'h1 to 4'hE) -> serial output stays 1,0,0,0.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the two-requester PISO arbiter: FSM states and requester ids.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_shifter.sv
// Right-shifting parallel-in/serial-out register with zero fill, LSB out first.
module piso_shifter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load)
            shreg_d = din;
        else if (shift_en)
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset)
            shreg_q <= '0;
        else
            shreg_q <= shreg_d;
    end

    assign sout = shreg_q[0];

endmodule

// File: rtl/piso_arbiter.sv
// Round-robin arbiter between two requesters feeding one serialiser.
// Define PISO_ARBITER_PARITY_EN to append an even-parity bit to every frame.
module piso_arbiter
    import piso_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         grant_id,
    output logic         busy,
    output logic         frame_done
);

`ifdef PISO_ARBITER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(FL - 1);
    localparam logic [CW-1:0] PENULT = CW'(FL - 2);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;
    logic          grant_q, grant_d;
    logic          sout_valid_q, sout_valid_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic          gnt0, gnt1, idle_ok, hs, sel_id, shift_out;
    logic [W-1:0]  sel_data;
    logic [FL-1:0] load_word;

    // On contention the round-robin pointer breaks the tie.
    assign gnt0     = req0_valid & (~req1_valid | (rr_q == REQ0));
    assign gnt1     = req1_valid & (~req0_valid | (rr_q == REQ1));
    assign idle_ok  = (state_q == IDLE) & reset;
    assign req0_ready = idle_ok & gnt0;
    assign req1_ready = idle_ok & gnt1;
    assign hs       = req0_ready | req1_ready;
    assign sel_id   = gnt1 ? REQ1 : REQ0;
    assign sel_data = gnt1 ? req1_data : req0_data;

`ifdef PISO_ARBITER_PARITY_EN
    assign load_word = {^sel_data, sel_data};
`else
    assign load_word = sel_data;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        grant_d      = grant_q;
        sout_valid_d = sout_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d      = SHIFT;
                    grant_d      = sel_id;
                    cnt_d        = '0;
                    sout_valid_d = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            SHIFT: begin
                // frame_done is registered, so raise it one bit early.
                frame_done_d = (cnt_q == PENULT);
                if (cnt_q == LAST) begin
                    state_d      = IDLE;
                    rr_d         = ~grant_q;
                    sout_valid_d = 1'b0;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_q         <= REQ0;
            grant_q      <= REQ0;
            sout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_q         <= rr_d;
            grant_q      <= grant_d;
            sout_valid_q <= sout_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    piso_shifter #(.WIDTH(FL)) u_shifter (
        .clk      (clk),
        .reset    (reset),
        .load     (hs),
        .shift_en (state_q == SHIFT),
        .din      (load_word),
        .sout     (shift_out)
    );

    assign sout       = shift_out & sout_valid_q;
    assign sout_valid = sout_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_piso_arbiter.sv
// Scoreboard bench for piso_arbiter: expected serial bits are queued when a
// frame is requested and popped by a monitor whenever sout_valid is high.
module tb_piso_arbiter;

    localparam int W = 4;
`ifdef PISO_ARBITER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_data = '0, req1_data = '0;
    logic         req0_ready, req1_ready;
    logic         sout, sout_valid, grant_id, busy, frame_done;

    typedef struct {
        logic b;
        logic last;
        logic gid;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    piso_arbiter #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d, input logic gid);
        logic [FL-1:0] w;
        w = FL'(d);
`ifdef PISO_ARBITER_PARITY_EN
        w[FL-1] = ^d;
`endif
        for (int i = 0; i < FL; i++)
            q.push_back('{b: w[i], last: (i == FL - 1), gid: gid});
    endtask

    always @(negedge clk) begin
        if (sout_valid) begin
            if (q.size() == 0) begin
                chk("extra_bit", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sout", sout, e.b);
                chk("frame_done", frame_done, e.last);
                chk("grant_id", grant_id, e.gid);
                chk("busy", busy, 1);
            end
        end else begin
            chk("idle_quiet", {busy, frame_done, sout}, 0);
        end
    end

    task automatic set_req(input logic id, input logic v, input logic [W-1:0] d);
        if (id) begin
            req1_valid = v;
            req1_data  = d;
        end else begin
            req0_valid = v;
            req0_data  = d;
        end
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !busy) done = 1;
        end
        chk("drain", done, 1);
    endtask

    // Single requester; data switches to d2 on the cycle after the handshake.
    task automatic send(input logic id, input logic [W-1:0] d, input logic [W-1:0] d2);
        push_frame(d, id);
        @(posedge clk); #1; set_req(id, 1'b1, d);
        @(negedge clk); chk("ready_hs", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
        @(posedge clk); #1; set_req(id, 1'b1, d2);
        @(negedge clk); chk("ready_shift", {req1_ready, req0_ready}, 0);
        @(posedge clk); #1; set_req(id, 1'b0, d2);
        wait_idle();
    endtask

    // Both requesters held valid from the same cycle; req0 is expected first.
    task automatic run_both(input logic [W-1:0] d0, input logic [W-1:0] d1);
        push_frame(d0, 1'b0);
        push_frame(d1, 1'b1);
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, d0);
        set_req(1'b1, 1'b1, d1);
        for (int c = 0; c < 2 * (FL + 1); c++) begin
            @(negedge clk);
            chk("both_ready", {req1_ready, req0_ready},
                (c == 0) ? 2'b01 : (c == FL + 1) ? 2'b10 : 2'b00);
            if (c == FL + 1) begin
                @(posedge clk); #1;
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("both_busy_end", busy, 0);
        chk("both_sb_empty", q.size(), 0);
    endtask

    initial begin
        // Reset with both requesters asserting: no ready may leak out.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready", {req1_ready, req0_ready}, 0);
        chk("rst_outs", {sout_valid, busy, frame_done, grant_id, sout}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        send(1'b1, 4'hF, 4'hF);   // only req1, rr=0
        run_both(4'hA, 4'h5);     // req0 then req1, one idle cycle between
        send(1'b0, 4'b1011, 4'b1011);
        send(1'b0, 4'b0111, 4'b0111);
        send(1'b0, 4'h1, 4'hE);   // data changes mid-frame

        // Abort during the second bit of a frame from req0 (data 6 -> 0,1,...).
        q.push_back('{b: 1'b0, last: 1'b0, gid: 1'b0});
        q.push_back('{b: 1'b1, last: 1'b0, gid: 1'b0});
        @(posedge clk); #1; set_req(1'b0, 1'b1, 4'h6);
        @(negedge clk); chk("abort_hs", req0_ready, 1);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_outs", {sout_valid, busy, frame_done, grant_id}, 0);
        @(posedge clk); #1; reset = 1'b1;
        chk("abort_sb_empty", q.size(), 0);
        run_both(4'h3, 4'hC);     // rr was 1 before reset; reset returns it to req0

        chk("final_sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
